bus_timer_slave: RTL and testbench
==================================

# bus_timer_slave

Bus responder that completes the initiator-side access protocol used by the CPU memory unit. It decodes chip-select, address strobe and read/write on the system bus and answers each access with a one-cycle active-low ready pulse and read data. Behind the bus port sits a 32-bit programmable interval timer with a sticky interrupt flag. It attaches to one slave port of the bus interconnect; its `irq` goes to the CPU interrupt controller.

## Interface
- `WAIT_CYCLES`, default 0: extra wait states inserted between request sample and `rdy_` (0..15).
- `clk  in  1`: single clock.
- `reset  in  1`: synchronous, active-high reset.
- `cs_  in  1`: chip select, active low, from interconnect address decode.
- `as_  in  1`: address strobe, active low.
- `rw  in  1`: 1 = read, 0 = write.
- `addr  in  3`: word-address bits [2:0] of the bus address.
- `wr_data  in  32`: write data.
- `rd_data  out  32`: read data, valid only while `rdy_`=0, else 0.
- `rdy_  out  1`: ready, active low, one-cycle pulse per access.
- `irq  out  1`: interrupt, level, equals INTR.flag.

## Operation
- Register map (word address): 0 CTRL {bit1 periodic, bit0 start}; 1 INTR {bit0 flag}; 2 EXPR[31:0]; 3 COUNT[31:0]; 4 PRESCALE[15:0] (macro only). Unused bits read 0. Unmapped addresses read 0, writes ignored, still acknowledged.
- Bus FSM: IDLE, WAIT, RESP.
  - IDLE: request = `cs_`=0 && `as_`=0. On request, latch `addr`/`rw`/`wr_data`; go to WAIT if `WAIT_CYCLES`>0 (load wait counter), else RESP.
  - WAIT: decrement counter; at 1, go to RESP.
  - RESP: drive `rdy_`=0 and, for reads, `rd_data` = register value sampled on entry to RESP; go to IDLE. Request inputs ignored in RESP. A new request can be sampled in the cycle after RESP.
- Writes commit at the clock edge ending RESP.
- Timer: when CTRL.start=1, each tick increments COUNT. If COUNT==EXPR on a tick: COUNT←0, INTR.flag←1; if CTRL.periodic=0, CTRL.start←0.
- INTR.flag is sticky; cleared only by a bus write of 0 to INTR bit0. Writing 1 sets it.
- Priorities in the same cycle: bus write to COUNT beats increment/clear. Expiry set beats a bus clear of INTR.flag. Expiry clearing start beats a bus write setting start only when periodic=0.
- EXPR=0 with start=1: expires on every tick.
- COUNT wraps 0xFFFF_FFFF→0 without setting the flag if EXPR is never matched.

## Timing
- Reset: FSM=IDLE, `rdy_`=1, `rd_data`=0, `irq`=0; CTRL, INTR, COUNT, PRESCALE = 0; EXPR = 0xFFFF_FFFF.
- Access latency: request sampled at edge T → `rdy_`=0 during cycle T+1+`WAIT_CYCLES`, exactly one cycle.
- `irq` is registered: it rises in the cycle after the expiring tick.
- Reset asserted mid-access aborts it: no `rdy_` pulse and no register write.

## Configuration
- `BUS_TIMER_PRESCALER_EN` defined: PRESCALE register is present at address 4. A 16-bit prescale counter generates one tick every PRESCALE+1 cycles, and it restarts at 0 whenever CTRL.start goes 0→1.
- Not defined: one tick every clock while start=1. Address 4 is unmapped.

## Test plan
- Reset, then read each address with `WAIT_CYCLES`=0 → `rdy_` low exactly one cycle after sample; data 0,0,0xFFFF_FFFF,0 (and 0 at address 4).
- Write EXPR=3, CTRL=0b01 → COUNT goes 0,1,2,3,0; `irq`=1 one cycle after the 3→0 tick; CTRL reads 0.
- Same setup with CTRL=0b11 → flag set every 4 ticks; write INTR=0 → `irq` drops; expiry in the same cycle as the clear → `irq` stays 1.
- `WAIT_CYCLES`=3, write COUNT=0x10 while running → `rdy_` at T+4; COUNT reads 0x10 next access, not an incremented value.
- Assert reset while in WAIT → no `rdy_`; all registers return to reset values.
- With the macro: PRESCALE=4, EXPR=1, start → `irq` rises after 10 cycles (+1 registered).

Source files
------------

// File: rtl/bus_timer_slave.sv
// bus_timer_slave: bus responder with a one-cycle active-low ready pulse in
// front of a 32-bit programmable interval timer with a sticky interrupt flag.
// Optional feature: define BUS_TIMER_PRESCALER_EN to add the PRESCALE register
// at word address 4 and a 16-bit tick prescaler.
module bus_timer_slave #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [2:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_,
  output logic        irq
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

  localparam logic [2:0] AddrCtrl  = 3'd0;
  localparam logic [2:0] AddrIntr  = 3'd1;
  localparam logic [2:0] AddrExpr  = 3'd2;
  localparam logic [2:0] AddrCount = 3'd3;
`ifdef BUS_TIMER_PRESCALER_EN
  localparam logic [2:0] AddrPre   = 3'd4;
`endif

  // Bus side state
  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_data_q, rd_data_d;

  // Timer registers
  logic        start_q, start_d;
  logic        periodic_q, periodic_d;
  logic        flag_q, flag_d;
  logic [31:0] expr_q, expr_d;
  logic [31:0] count_q, count_d;
`ifdef BUS_TIMER_PRESCALER_EN
  logic [15:0] pre_q, pre_d;
  logic [15:0] pcnt_q, pcnt_d;
`endif

  logic [2:0]  rd_addr;
  logic [31:0] reg_rdata;
  logic        bus_we;
  logic        tick;
  logic        expire;

  // With no wait states the read snapshot is taken from the live address.
  assign rd_addr = (state_q == StIdle) ? addr : addr_q;

  // Register read mux; unused bits and unmapped addresses read 0
  always_comb begin
    reg_rdata = '0;
    case (rd_addr)
      AddrCtrl:  reg_rdata = {30'b0, periodic_q, start_q};
      AddrIntr:  reg_rdata = {31'b0, flag_q};
      AddrExpr:  reg_rdata = expr_q;
      AddrCount: reg_rdata = count_q;
`ifdef BUS_TIMER_PRESCALER_EN
      AddrPre:   reg_rdata = {16'b0, pre_q};
`endif
      default:   reg_rdata = '0;
    endcase
  end

  // Bus FSM: request capture, wait states, one-cycle response
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    rd_data_d  = '0;
    bus_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!cs_ && !as_) begin
          addr_d  = addr;
          rw_d    = rw;
          wdata_d = wr_data;
          if (WAIT_CYCLES != 0) begin
            state_d    = StWait;
            wait_cnt_d = WaitLoad;
          end else begin
            state_d = StResp;
            if (rw) rd_data_d = reg_rdata;
          end
        end
      end
      StWait: begin
        if (wait_cnt_q == 4'd1) begin
          state_d = StResp;
          if (rw_q) rd_data_d = reg_rdata;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
        bus_we  = !rw_q;
      end
      default: state_d = StIdle;
    endcase
  end

  // Timer tick, expiry and register next-state with bus-write priorities
  always_comb begin
`ifdef BUS_TIMER_PRESCALER_EN
    tick   = start_q && (pcnt_q == pre_q);
    pcnt_d = (!start_q || (pcnt_q == pre_q)) ? 16'd0 : pcnt_q + 16'd1;
    pre_d  = (bus_we && addr_q == AddrPre) ? wdata_q[15:0] : pre_q;
`else
    tick   = start_q;
`endif
    expire     = tick && (count_q == expr_q);
    start_d    = start_q;
    periodic_d = periodic_q;
    flag_d     = flag_q;
    expr_d     = expr_q;
    count_d    = count_q;

    if (tick) count_d = expire ? 32'd0 : count_q + 32'd1;
    if (expire && !periodic_q) start_d = 1'b0;

    if (bus_we) begin
      case (addr_q)
        AddrCtrl: begin
          periodic_d = wdata_q[1];
          // A one-shot expiry in the same cycle keeps start cleared.
          start_d    = wdata_q[0] && !(expire && !periodic_q);
        end
        AddrIntr:  flag_d  = wdata_q[0];
        AddrExpr:  expr_d  = wdata_q;
        AddrCount: count_d = wdata_q;
        default: ;
      endcase
    end

    // Expiry always wins over a software clear.
    if (expire) flag_d = 1'b1;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      start_q    <= 1'b0;
      periodic_q <= 1'b0;
      flag_q     <= 1'b0;
      expr_q     <= 32'hFFFF_FFFF;
      count_q    <= '0;
`ifdef BUS_TIMER_PRESCALER_EN
      pre_q      <= '0;
      pcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      start_q    <= start_d;
      periodic_q <= periodic_d;
      flag_q     <= flag_d;
      expr_q     <= expr_d;
      count_q    <= count_d;
`ifdef BUS_TIMER_PRESCALER_EN
      pre_q      <= pre_d;
      pcnt_q     <= pcnt_d;
`endif
    end
  end

  assign rdy_    = (state_q != StResp);
  assign rd_data = rd_data_q;
  assign irq     = flag_q;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Bench for bus_timer_slave: two instances (0 and 3 wait states) share the bus
// inputs; each is compared every cycle against an edge-level reference model.
module tb_bus_timer_slave;

  logic        clk;
  logic        reset;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [2:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data0, rd_data1;
  logic        rdy_0, rdy_1;
  logic        irq0, irq1;

  int n_vec;
  int n_err;
  int edge_n;

  bus_timer_slave #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data0), .rdy_(rdy_0), .irq(irq0)
  );

  bus_timer_slave #(.WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data1), .rdy_(rdy_1), .irq(irq1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: architectural registers plus one pending access whose
  // response edge is known from the moment it is accepted.
  typedef struct packed {
    logic        start;
    logic        periodic;
    logic        flag;
    logic [31:0] expr;
    logic [31:0] count;
    logic [15:0] pre;
    logic [15:0] pcnt;
    logic        busy;
    int          resp_e;
    logic        arw;
    logic [2:0]  aaddr;
    logic [31:0] adata;
    logic        exp_rdy_n;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } mdl_t;

  mdl_t m0, m1;

  function automatic logic [31:0] mdl_read(input mdl_t s, input logic [2:0] a);
    case (a)
      3'd0: return {30'b0, s.periodic, s.start};
      3'd1: return {31'b0, s.flag};
      3'd2: return s.expr;
      3'd3: return s.count;
`ifdef BUS_TIMER_PRESCALER_EN
      3'd4: return {16'b0, s.pre};
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input int w, input int e, input logic r,
                                    input logic c, input logic a_s, input logic wr,
                                    input logic [2:0] ad, input logic [31:0] d);
    mdl_t n;
    logic tk, ex;
    n = s;
    if (r) begin
      n = '0;
      n.expr      = 32'hFFFF_FFFF;
      n.exp_rdy_n = 1'b1;
      return n;
    end
`ifdef BUS_TIMER_PRESCALER_EN
    tk     = s.start && (s.pcnt == s.pre);
    n.pcnt = (!s.start || s.pcnt == s.pre) ? 16'd0 : s.pcnt + 16'd1;
`else
    tk = s.start;
`endif
    ex = tk && (s.count == s.expr);
    if (tk) n.count = ex ? 32'd0 : s.count + 32'd1;
    if (ex) begin
      n.flag = 1'b1;
      if (!s.periodic) n.start = 1'b0;
    end
    // Access finishing at this edge: writes take effect now.
    if (s.busy && e == s.resp_e + 1) begin
      n.busy = 1'b0;
      if (!s.arw) begin
        case (s.aaddr)
          3'd0: begin
            n.periodic = s.adata[1];
            n.start    = s.adata[0] && !(ex && !s.periodic);
          end
          3'd1: n.flag  = s.adata[0] || ex;
          3'd2: n.expr  = s.adata;
          3'd3: n.count = s.adata;
`ifdef BUS_TIMER_PRESCALER_EN
          3'd4: n.pre   = s.adata[15:0];
`endif
          default: ;
        endcase
      end
    end
    if (!s.busy && !c && !a_s) begin
      n.busy   = 1'b1;
      n.resp_e = e + w;
      n.arw    = wr;
      n.aaddr  = ad;
      n.adata  = d;
    end
    n.exp_rdy_n = 1'b1;
    n.exp_rd    = 32'd0;
    if (n.busy && e == n.resp_e) begin
      n.exp_rdy_n = 1'b0;
      if (n.arw) n.exp_rd = mdl_read(s, n.aaddr);
    end
    n.exp_irq = n.flag;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %h, want %h", tag, edge_n, obs, exp);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at negedge.
  task automatic step(input logic r, input logic c, input logic a_s, input logic wr,
                      input logic [2:0] ad, input logic [31:0] d);
    reset   = r;
    cs_     = c;
    as_     = a_s;
    rw      = wr;
    addr    = ad;
    wr_data = d;
    @(posedge clk);
    m0 = mdl_step(m0, 0, edge_n, r, c, a_s, wr, ad, d);
    m1 = mdl_step(m1, 3, edge_n, r, c, a_s, wr, ad, d);
    edge_n++;
    @(negedge clk);
    check("rdy_w0",    {31'b0, rdy_0}, {31'b0, m0.exp_rdy_n});
    check("rd_data_w0", rd_data0,      m0.exp_rd);
    check("irq_w0",    {31'b0, irq0},  {31'b0, m0.exp_irq});
    check("rdy_w3",    {31'b0, rdy_1}, {31'b0, m1.exp_rdy_n});
    check("rd_data_w3", rd_data1,      m1.exp_rd);
    check("irq_w3",    {31'b0, irq1},  {31'b0, m1.exp_irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic access(input logic wr, input logic [2:0] ad, input logic [31:0] d);
    step(1'b0, 1'b0, 1'b0, wr, ad, d);
    idle(6);
  endtask

  logic [31:0] rdata;
  logic [2:0]  raddr;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    edge_n  = 0;
    reset   = 1'b1;
    cs_     = 1'b1;
    as_     = 1'b1;
    rw      = 1'b0;
    addr    = 3'd0;
    wr_data = 32'd0;
    @(negedge clk);

    step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd0);
    idle(1);
    // Reset values at every address
    for (int a = 0; a < 8; a++) access(1'b1, 3'(a), 32'd0);
    // One-shot expiry at EXPR=3
    access(1'b0, 3'd2, 32'd3);
    access(1'b0, 3'd0, 32'd1);
    idle(8);
    access(1'b1, 3'd0, 32'd0);
    // Periodic mode, then software clears including one near an expiry
    access(1'b0, 3'd0, 32'd3);
    idle(5);
    access(1'b0, 3'd1, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 32'd0);
      idle(k + 1);
    end
    // Count overwrite while running
    access(1'b0, 3'd3, 32'h10);
    access(1'b1, 3'd3, 32'd0);
    // Counter wrap without a match
    access(1'b0, 3'd2, 32'h100);
    access(1'b0, 3'd3, 32'hFFFF_FFFD);
    idle(6);
    // Reset in the middle of a waited access
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 32'h55);
    idle(1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd0);
    idle(6);
    for (int a = 0; a < 5; a++) access(1'b1, 3'(a), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      raddr = ($urandom % 4 == 0) ? 3'($urandom % 8) : 3'($urandom % 4);
      case ($urandom % 4)
        0: rdata = $urandom;
        1: rdata = 32'($urandom % 8);
        2: rdata = 32'hFFFF_FFF0 + 32'($urandom % 16);
        default: rdata = 32'($urandom % 4);
      endcase
      step(($urandom % 500) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
           1'($urandom % 2), raddr, rdata);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
